// File: rtl/restoring_div_ctrl.sv
// ============================================================================
// Module   : restoring_div_ctrl
// Purpose  : Iterative unsigned restoring divider. Each clock performs one
//            shift / trial-subtract / restore step.
//            Optional macro DIV_EARLY_SKIP_EN skips the dividend's leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_ctrl #(
    parameter int BIT   = 16,
    parameter int CNT_W = $clog2(BIT + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [BIT-1:0] dividend,
    input  logic [BIT-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [BIT-1:0] quotient,
    output logic [BIT-1:0] remainder,
    output logic           div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(BIT);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_n;
    logic [BIT-1:0]   r_r;
    logic [BIT-1:0]   r_q;
    logic [BIT-1:0]   r_d;
    logic [BIT-1:0]   r_quot;
    logic [BIT-1:0]   r_rem;
    logic             r_dbz;
    logic [BIT-1:0]   w_q_init;
    logic             w_div_zero;

    logic [BIT:0]     w_r_sh;
    logic [BIT-1:0]   w_r_sub;
    logic [BIT-1:0]   w_r_new;
    logic             w_ge;
    logic [BIT-1:0]   w_q_new;

    assign w_div_zero = (divisor == '0);

`ifdef DIV_EARLY_SKIP_EN
    // Bit length of the dividend sets the iteration count; a zero dividend needs none.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < BIT; i++) begin
            if (dividend[i]) begin
                w_n = CNT_W'(i + 1);
            end
        end
    end
    assign w_q_init = dividend << (c_FULL - w_n);
`else
    assign w_n      = c_FULL;
    assign w_q_init = dividend;
`endif

    // R < D always holds, so the shifted remainder needs one extra bit to
    // compare correctly; the difference itself always fits in BIT bits.
    assign w_r_sh  = {r_r, r_q[BIT-1]};
    assign w_ge    = (w_r_sh >= {1'b0, r_d});
    assign w_r_sub = w_r_sh[BIT-1:0] - r_d;
    assign w_r_new = w_ge ? w_r_sub : w_r_sh[BIT-1:0];
    assign w_q_new = {r_q[BIT-2:0], w_ge};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_div_zero || (w_n == '0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (r_cnt == c_ONE) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_ITER:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration and result latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_dbz <= 1'b0;
                            r_d   <= divisor;
                            r_r   <= '0;
                            r_q   <= w_q_init;
                            r_cnt <= w_n;
                            if (w_n == '0) begin
                                r_quot <= '0;
                                r_rem  <= '0;
                            end
                        end
                    end
                end
                S_ITER: begin
                    r_r   <= w_r_new;
                    r_q   <= w_q_new;
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_quot <= w_q_new;
                        r_rem  <= w_r_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
